// File: rtl/alien_pkg.sv
// Shared definitions for the alien hit scheduler.
//   Geometry of the alien formation, FSM state encoding, counter widths,
//   and the per-row point value used when ALIEN_SCORE_EN is defined.
package alien_pkg;

    localparam int N_COLS    = 8;
    localparam int N_ROWS    = 6;
    localparam int N         = N_COLS * N_ROWS;
    localparam int ALIEN_W   = 16;
    localparam int ALIEN_H   = 16;
    localparam int SPACING_X = 32;
    localparam int SPACING_Y = 24;
    localparam int GROUND_Y  = 440;
    localparam int PTS_ROW0  = 30;

    localparam int IDX_W = 6;
    localparam int COL_W = $clog2(N_COLS);
    localparam int ROW_W = $clog2(N_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HIT  = 2'd2
    } state_e;

    // Row 0 is worth PTS_ROW0, each lower row 10 less, never below 10.
    function automatic logic [15:0] row_points(input logic [ROW_W-1:0] row);
        int pts;
        pts = PTS_ROW0 - 10 * int'(row);
        if (pts < 10) pts = 10;
        return 16'(pts);
    endfunction

endpackage

// File: rtl/alien_pos_gen.sv
// Alien position generator.
//   Walks the formation in index order (row-major) and accumulates the
//   screen position of the current alien by addition only.
// Ports:
//   clk_master, d_reset   clock, async active-high reset
//   start                 load origin, clear idx/col/row
//   step                  advance to the next alien
//   origin_x, origin_y    formation top-left, sampled on start
//   idx                   current alien index (row*N_COLS+col)
//   row                   current row (only with ALIEN_SCORE_EN)
//   ax, ay                11-bit position of the current alien
//   last                  current alien is index N-1
// Macro: ALIEN_SCORE_EN exposes the row output.
module alien_pos_gen
    import alien_pkg::*;
(
    input  logic             clk_master,
    input  logic             d_reset,
    input  logic             start,
    input  logic             step,
    input  logic [9:0]       origin_x,
    input  logic [9:0]       origin_y,
    output logic [IDX_W-1:0] idx,
`ifdef ALIEN_SCORE_EN
    output logic [ROW_W-1:0] row,
`endif
    output logic [10:0]      ax,
    output logic [10:0]      ay,
    output logic             last
);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [9:0]       org_x_q;

    always_ff @(posedge clk_master or posedge d_reset) begin
        if (d_reset) begin
            idx     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ax      <= '0;
            ay      <= '0;
            org_x_q <= '0;
        end else if (start) begin
            idx     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ax      <= {1'b0, origin_x};
            ay      <= {1'b0, origin_y};
            org_x_q <= origin_x;
        end else if (step) begin
            idx <= idx + 1'b1;
            if (col_q == COL_W'(N_COLS - 1)) begin
                // Row wrap: x returns to the latched origin, y moves one pitch down.
                col_q <= '0;
                row_q <= row_q + 1'b1;
                ax    <= {1'b0, org_x_q};
                ay    <= ay + 11'(SPACING_Y);
            end else begin
                col_q <= col_q + 1'b1;
                ax    <= ax + 11'(SPACING_X);
            end
        end
    end

    assign last = (idx == IDX_W'(N - 1));

`ifdef ALIEN_SCORE_EN
    assign row = row_q;
`endif

endmodule

// File: rtl/alien_hit_scheduler.sv
// Alien hit scheduler.
//   Checks the player projectile against one alien per clock, owns the
//   alive mask, reports the destroyed alien and flags wave-clear/game-over.
//
//   state | meaning
//   IDLE  | waiting for frame_tick
//   SCAN  | evaluating alien idx this cycle
//   HIT   | hit outputs pulsing, returning to IDLE
//
// Ports:
//   clk_master, d_reset          clock, async active-high reset
//   frame_tick                   start a scan (ignored unless IDLE)
//   wave_reload                  restore all aliens, clear game_over
//   origin_x, origin_y           formation top-left
//   proj_valid, projectile_x/y   projectile state
//   alive_mask                   bit i = alien i alive
//   hit_valid, del_proj          1-cycle pulse on a kill
//   hit_index                    last destroyed alien
//   all_dead                     registered alive_mask == 0
//   game_over                    sticky ground-reached flag
//   busy                         high in SCAN
//   score                        running score (only with ALIEN_SCORE_EN)
// Macro: ALIEN_SCORE_EN adds the score output and its logic.
module alien_hit_scheduler
    import alien_pkg::*;
(
    input  logic             clk_master,
    input  logic             d_reset,
    input  logic             frame_tick,
    input  logic             wave_reload,
    input  logic [9:0]       origin_x,
    input  logic [9:0]       origin_y,
    input  logic             proj_valid,
    input  logic [9:0]       projectile_x,
    input  logic [9:0]       projectile_y,
    output logic [N-1:0]     alive_mask,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_index,
    output logic             del_proj,
    output logic             all_dead,
    output logic             game_over,
`ifdef ALIEN_SCORE_EN
    output logic [15:0]      score,
`endif
    output logic             busy
);

    state_e           state_q, state_d;
    logic             scan_start, scan_step;
    logic [IDX_W-1:0] idx;
    logic [10:0]      ax, ay, px, py;
    logic             last;
    logic             cur_alive, x_in, y_in, hit_now, hit_take, ground_now;
`ifdef ALIEN_SCORE_EN
    logic [ROW_W-1:0] row;
    logic [16:0]      score_sum;
`endif

    alien_pos_gen u_pos_gen (
        .clk_master (clk_master),
        .d_reset    (d_reset),
        .start      (scan_start),
        .step       (scan_step),
        .origin_x   (origin_x),
        .origin_y   (origin_y),
        .idx        (idx),
`ifdef ALIEN_SCORE_EN
        .row        (row),
`endif
        .ax         (ax),
        .ay         (ay),
        .last       (last)
    );

    assign px        = {1'b0, projectile_x};
    assign py        = {1'b0, projectile_y};
    assign cur_alive = alive_mask[idx];

    // Positions at or beyond 1024 are off-screen and can never be hit.
    assign x_in = (ax < 11'd1024) && (ax <= px) && (px < ax + 11'(ALIEN_W));
    assign y_in = (ay < 11'd1024) && (ay <= py) && (py < ay + 11'(ALIEN_H));

    assign hit_now    = (state_q == SCAN) && proj_valid && cur_alive && x_in && y_in;
    assign hit_take   = hit_now && !wave_reload;
    assign ground_now = (state_q == SCAN) && cur_alive &&
                        (({1'b0, ay} + 12'(ALIEN_H)) > 12'(GROUND_Y));

    always_ff @(posedge clk_master or posedge d_reset) begin
        if (d_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        scan_start = 1'b0;
        scan_step  = 1'b0;
        if (wave_reload) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_d    = SCAN;
                        scan_start = 1'b1;
                    end
                end
                SCAN: begin
                    if (hit_now)   state_d = HIT;
                    else if (last) state_d = IDLE;
                    else           scan_step = 1'b1;
                end
                HIT:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == SCAN);

    // Hit results are registered on the SCAN->HIT edge so they are visible
    // during the HIT cycle, giving k+2 cycles from tick to pulse.
    always_ff @(posedge clk_master or posedge d_reset) begin
        if (d_reset) begin
            alive_mask <= '1;
            hit_valid  <= 1'b0;
            del_proj   <= 1'b0;
            hit_index  <= '0;
            game_over  <= 1'b0;
            all_dead   <= 1'b0;
        end else begin
            hit_valid <= hit_take;
            del_proj  <= hit_take;
            if (hit_take) hit_index <= idx;
            if (wave_reload) begin
                alive_mask <= '1;
                game_over  <= 1'b0;
            end else begin
                if (hit_take)   alive_mask[idx] <= 1'b0;
                if (ground_now) game_over <= 1'b1;
            end
            all_dead <= (alive_mask == '0);
        end
    end

`ifdef ALIEN_SCORE_EN
    assign score_sum = {1'b0, score} + {1'b0, row_points(row)};

    always_ff @(posedge clk_master or posedge d_reset) begin
        if (d_reset)       score <= '0;
        else if (hit_take) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_alien_hit_scheduler.sv
module tb_alien_hit_scheduler;

    logic        clk_master = 1'b0;
    logic        d_reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        wave_reload = 1'b0;
    logic [9:0]  origin_x = '0;
    logic [9:0]  origin_y = '0;
    logic        proj_valid = 1'b0;
    logic [9:0]  projectile_x = '0;
    logic [9:0]  projectile_y = '0;
    logic [47:0] alive_mask;
    logic        hit_valid;
    logic [5:0]  hit_index;
    logic        del_proj;
    logic        all_dead;
    logic        game_over;
    logic        busy;
`ifdef ALIEN_SCORE_EN
    logic [15:0] score;
`endif

    int checks = 0;
    int failures = 0;

    alien_hit_scheduler dut (
        .clk_master   (clk_master),
        .d_reset      (d_reset),
        .frame_tick   (frame_tick),
        .wave_reload  (wave_reload),
        .origin_x     (origin_x),
        .origin_y     (origin_y),
        .proj_valid   (proj_valid),
        .projectile_x (projectile_x),
        .projectile_y (projectile_y),
        .alive_mask   (alive_mask),
        .hit_valid    (hit_valid),
        .hit_index    (hit_index),
        .del_proj     (del_proj),
        .all_dead     (all_dead),
        .game_over    (game_over),
`ifdef ALIEN_SCORE_EN
        .score        (score),
`endif
        .busy         (busy)
    );

    always #5 clk_master = ~clk_master;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_master);
        #1;
    endtask

    // Issues frame_tick, then watches 60 cycles. Cycle 1 is the first
    // sample after the edge that took the tick. mid_tick / reload_at
    // (0 = never) pulse frame_tick / wave_reload in that cycle.
    task automatic run_frame(input logic [9:0] ox, input logic [9:0] oy,
                             input logic pv, input logic [9:0] prx, input logic [9:0] pry,
                             input int mid_tick, input int reload_at,
                             output int busy_cnt, output int hit_cnt, output int first_hit,
                             output int coin_err, output logic ad_at_hit, output logic ad_after);
        busy_cnt = 0; hit_cnt = 0; first_hit = 0; coin_err = 0;
        ad_at_hit = 1'bx; ad_after = 1'bx;
        origin_x = ox; origin_y = oy;
        proj_valid = pv; projectile_x = prx; projectile_y = pry;
        frame_tick = 1'b1;
        cyc();
        for (int c = 1; c <= 60; c++) begin
            if (busy) busy_cnt++;
            if (hit_valid) begin
                hit_cnt++;
                if (first_hit == 0) begin
                    first_hit = c;
                    ad_at_hit = all_dead;
                end
            end
            if (first_hit != 0 && c == first_hit + 1) ad_after = all_dead;
            if (del_proj !== hit_valid) coin_err++;
            frame_tick  = (c == mid_tick);
            wave_reload = (c == reload_at);
            cyc();
        end
        frame_tick  = 1'b0;
        wave_reload = 1'b0;
    endtask

    int          bc, hc, fh, ce;
    logic        a0, a1;
    logic [47:0] exp_mask;
    int          ax_e, ay_e;

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_alive", alive_mask, 48'hFFFF_FFFF_FFFF);
        chk("rst_busy", busy, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_all_dead", all_dead, 0);
        chk("rst_hit_index", hit_index, 0);
        d_reset = 1'b0;
        cyc();

        // 1: full scan with no projectile
        run_frame(10'd100, 10'd50, 1'b0, 10'd133, 10'd77, 0, 0, bc, hc, fh, ce, a0, a1);
        chk("s1_busy_len", bc, 48);
        chk("s1_hits", hc, 0);
        chk("s1_alive", alive_mask, 48'hFFFF_FFFF_FFFF);

        // 2: alien 9 at (132,74) hit by (133,77)
        run_frame(10'd100, 10'd50, 1'b1, 10'd133, 10'd77, 0, 0, bc, hc, fh, ce, a0, a1);
        chk("s2_hit_cycle", fh, 11);
        chk("s2_hit_count", hc, 1);
        chk("s2_coincident", ce, 0);
        chk("s2_busy_len", bc, 10);
        chk("s2_hit_index", hit_index, 9);
        chk("s2_alive", alive_mask, 48'hFFFF_FFFF_FDFF);
`ifdef ALIEN_SCORE_EN
        chk("s2_score", score, 20);
`endif

        // 3: same frame again, alien 9 dead; extra tick mid-scan ignored
        run_frame(10'd100, 10'd50, 1'b1, 10'd133, 10'd77, 5, 0, bc, hc, fh, ce, a0, a1);
        chk("s3_hits", hc, 0);
        chk("s3_busy_len", bc, 48);
        chk("s3_alive", alive_mask, 48'hFFFF_FFFF_FDFF);
        chk("s3_game_over", game_over, 0);

        // 4: ground boundary
        run_frame(10'd100, 10'd300, 1'b0, 10'd0, 10'd0, 0, 0, bc, hc, fh, ce, a0, a1);
        chk("s4_bottom_436", game_over, 0);
        run_frame(10'd100, 10'd305, 1'b0, 10'd0, 10'd0, 0, 0, bc, hc, fh, ce, a0, a1);
        chk("s4_bottom_441", game_over, 1);
        run_frame(10'd100, 10'd300, 1'b0, 10'd0, 10'd0, 0, 0, bc, hc, fh, ce, a0, a1);
        chk("s4_sticky", game_over, 1);
        wave_reload = 1'b1;
        cyc();
        wave_reload = 1'b0;
        chk("s4_reload_go", game_over, 0);
        chk("s4_reload_alive", alive_mask, 48'hFFFF_FFFF_FFFF);

        // wave_reload in the same cycle as a hit on alien 0 wins
        run_frame(10'd100, 10'd50, 1'b1, 10'd101, 10'd51, 0, 1, bc, hc, fh, ce, a0, a1);
        chk("rl_pri_hits", hc, 0);
        chk("rl_pri_busy", bc, 1);
        chk("rl_pri_alive", alive_mask, 48'hFFFF_FFFF_FFFF);

        // 5: kill all 48, one per frame
        exp_mask = '1;
        for (int k = 0; k < 48; k++) begin
            ax_e = 100 + 32 * (k % 8);
            ay_e = 50 + 24 * (k / 8);
            run_frame(10'd100, 10'd50, 1'b1, 10'(ax_e + 1), 10'(ay_e + 1), 0, 0,
                      bc, hc, fh, ce, a0, a1);
            exp_mask[k] = 1'b0;
            chk($sformatf("s5_cycle_%0d", k), fh, k + 2);
            chk($sformatf("s5_index_%0d", k), hit_index, k);
            chk($sformatf("s5_alive_%0d", k), alive_mask, exp_mask);
            chk($sformatf("s5_ad_at_hit_%0d", k), a0, 0);
            chk($sformatf("s5_ad_after_%0d", k), a1, (k == 47) ? 1 : 0);
        end
        chk("s5_all_dead", all_dead, 1);

        // Scan with everything dead still runs but never hits
        run_frame(10'd100, 10'd50, 1'b1, 10'd101, 10'd51, 0, 0, bc, hc, fh, ce, a0, a1);
        chk("dead_busy_len", bc, 48);
        chk("dead_hits", hc, 0);

        // Async reset mid-scan
        origin_x = 10'd100; origin_y = 10'd50; proj_valid = 1'b0;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (5) cyc();
        chk("mid_busy_before", busy, 1);
        d_reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alive", alive_mask, 48'hFFFF_FFFF_FFFF);
        chk("mid_rst_all_dead", all_dead, 0);
        cyc();
        d_reset = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
